result_writer: RTL and testbench

Back end of the convolution datapath's result interface. Accepts the single-cycle `result_data`/`result_valid` stream produced after max-pool. Saturates each 20-bit signed result to 8 bits, packs three results per 24-bit word in the same lane order as `img_data`, and writes the words row by row into output feature-map memory. The block sits between the datapath and the output SRAM write port. It is controlled by the same top-level sequencer that pulses `start`.

---
 rtl/result_writer_pkg.sv | 18 +
 rtl/result_writer_sat8.sv | 35 +++
 rtl/result_writer.sv | 153 +++++++++++++++
 tb/tb_result_writer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_writer_pkg.sv
// Shared types and constants for the result writer.
// Lane geometry, saturation bounds and FSM encodings.
package result_writer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int LANES    = 3;
  localparam int LANE_W   = 8;

  localparam int SAT_MAX  = 127;
  localparam int SAT_MIN  = -128;
  localparam int RELU_MIN = 0;

endpackage

// File: rtl/result_writer_sat8.sv
// Signed result to 8-bit lane saturator with clip indication.
// RESULT_WRITER_RELU_EN selects a [0,127] range; negatives clip silently.
module sat8
  import result_writer_pkg::*;
#(
  parameter int W = 20
) (
  input  logic signed [W-1:0]      d,
  output logic        [LANE_W-1:0] q,
  output logic                     clipped
);

  localparam logic signed [W-1:0] HI = W'(SAT_MAX);
`ifdef RESULT_WRITER_RELU_EN
  localparam logic signed [W-1:0] LO = W'(RELU_MIN);
  localparam logic CLIP_LO = 1'b0;
`else
  localparam logic signed [W-1:0] LO = W'(SAT_MIN);
  localparam logic CLIP_LO = 1'b1;
`endif

  // clamp to [LO, HI]; only a clamp that loses information is flagged
  always_comb begin
    q       = d[LANE_W-1:0];
    clipped = 1'b0;
    if (d > HI) begin
      q       = HI[LANE_W-1:0];
      clipped = 1'b1;
    end else if (d < LO) begin
      q       = LO[LANE_W-1:0];
      clipped = CLIP_LO;
    end
  end

endmodule

// File: rtl/result_writer.sv
// Packs saturated results three per word and writes them row by row.
// Build option RESULT_WRITER_RELU_EN: ReLU before saturation.
module result_writer
  import result_writer_pkg::*;
#(
  parameter int RESULT_DWIDTH = 20,
  parameter int OUT_DWIDTH    = 24,
  parameter int ADDR_WIDTH    = 12,
  parameter int DIM_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic [DIM_WIDTH-1:0]     out_cols,
  input  logic [DIM_WIDTH-1:0]     out_rows,
  input  logic [RESULT_DWIDTH-1:0] result_data,
  input  logic                     result_valid,
  output logic                     mem_wr_en,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [OUT_DWIDTH-1:0]    mem_wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     sat_flag,
  output logic                     unexp_valid
);

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DIM_WIDTH-1:0]   cols_q, rows_q;
  logic [DIM_WIDTH-1:0]   col_cnt, row_cnt;
  logic [1:0]             lane_cnt;
  logic [LANE_W-1:0]      lane0_q, lane1_q;
  logic [LANE_W-1:0]      byte_s;
  logic                   clip_s;
  logic                   arm, take;
  logic                   last_col, last_row, word_end;
  logic [LANES*LANE_W-1:0] word_s;

  sat8 #(.W(RESULT_DWIDTH)) u_sat (
    .d       (result_data),
    .q       (byte_s),
    .clipped (clip_s)
  );

  assign arm      = (state_q == IDLE) && start;
  assign take     = (state_q == RUN) && result_valid;
  assign last_col = col_cnt == cols_q - DIM_WIDTH'(1);
  assign last_row = row_cnt == rows_q - DIM_WIDTH'(1);
  assign word_end = (lane_cnt == 2'd2) || last_col;

  assign busy = state_q == RUN;
  assign done = state_q == DONE;

  // current sample merged into the partial word, upper lanes zeroed
  always_comb begin
    word_s = '0;
    unique case (1'b1)
      lane_cnt == 2'd2: word_s = {byte_s, lane1_q, lane0_q};
      lane_cnt == 2'd1: word_s = {8'h00, byte_s, lane0_q};
      default:          word_s = {16'h0000, byte_s};
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state: empty maps skip straight to DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (out_cols == '0 || out_rows == '0) state_d = DONE;
          else                                  state_d = RUN;
        end
      end
      RUN:  if (take && last_col && last_row) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // configuration latch and lane/column/row/address counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      cols_q   <= '0;
      rows_q   <= '0;
      col_cnt  <= '0;
      row_cnt  <= '0;
      lane_cnt <= '0;
      lane0_q  <= '0;
      lane1_q  <= '0;
    end else if (arm) begin
      addr_q   <= base_addr;
      cols_q   <= out_cols;
      rows_q   <= out_rows;
      col_cnt  <= '0;
      row_cnt  <= '0;
      lane_cnt <= '0;
    end else if (take) begin
      if (lane_cnt == 2'd0) lane0_q <= byte_s;
      if (lane_cnt == 2'd1) lane1_q <= byte_s;
      if (word_end) begin
        addr_q   <= addr_q + ADDR_WIDTH'(1);
        lane_cnt <= '0;
      end else begin
        lane_cnt <= lane_cnt + 2'd1;
      end
      if (last_col) begin
        col_cnt <= '0;
        row_cnt <= row_cnt + DIM_WIDTH'(1);
      end else begin
        col_cnt <= col_cnt + DIM_WIDTH'(1);
      end
    end
  end

  // registered write port: one strobe per completed word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
    end else begin
      mem_wr_en <= 1'b0;
      if (take && word_end) begin
        mem_wr_en   <= 1'b1;
        mem_addr    <= addr_q;
        mem_wr_data <= OUT_DWIDTH'(word_s);
      end
    end
  end

  // sticky status, cleared on arm; a stray valid always wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_flag    <= 1'b0;
      unexp_valid <= 1'b0;
    end else begin
      if (arm)               sat_flag <= 1'b0;
      else if (take && clip_s) sat_flag <= 1'b1;
      if (arm)               unexp_valid <= 1'b0;
      if (result_valid && state_q != RUN) unexp_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_result_writer.sv
// Directed vector bench for result_writer.
// Expected words are hand-computed; RELU build selects alternate values.
module tb_result_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [11:0] base_addr;
  logic [7:0]  out_cols, out_rows;
  logic [19:0] result_data;
  logic        result_valid;
  logic        mem_wr_en;
  logic [11:0] mem_addr;
  logic [23:0] mem_wr_data;
  logic        busy, done, sat_flag, unexp_valid;

  result_writer dut (
    .clk          (clk),
    .reset        (reset_n),
    .start        (start),
    .base_addr    (base_addr),
    .out_cols     (out_cols),
    .out_rows     (out_rows),
    .result_data  (result_data),
    .result_valid (result_valid),
    .mem_wr_en    (mem_wr_en),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .busy         (busy),
    .done         (done),
    .sat_flag     (sat_flag),
    .unexp_valid  (unexp_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]        cols;
    logic [7:0]        rows;
    logic [11:0]       base;
    logic [3:0]        n;
    logic              gap;
    logic [7:0][19:0]  samp;
    logic [2:0]        nw;
    logic [3:0][11:0]  wa;
    logic [3:0][23:0]  wd;
    logic              sat;
  } vec_t;

  vec_t vecs [5];

  int nchk = 0;
  int nfail = 0;

  logic [11:0] wa_q [$];
  logic [23:0] wd_q [$];
  int done_cnt = 0;
  int done_wr  = 0;

  always @(negedge clk) begin
    if (mem_wr_en) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wr_data);
    end
    if (done) begin
      done_cnt++;
      if (mem_wr_en) done_wr++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr_mon();
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
    done_wr  = 0;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    clr_mon();
    out_cols  = v.cols;
    out_rows  = v.rows;
    base_addr = v.base;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    chk($sformatf("v%0d busy", k), 32'(busy), 32'd1);
    for (int i = 0; i < int'(v.n); i++) begin
      result_valid = 1'b1;
      result_data  = v.samp[i];
      tick();
      result_valid = 1'b0;
      if (v.gap) tick();
    end
    for (int t = 0; t < 20 && done_cnt == 0; t++) tick();
    tick();
    tick();
    chk($sformatf("v%0d done_cnt", k), 32'(done_cnt), 32'd1);
    chk($sformatf("v%0d done_w_wr", k), 32'(done_wr), 32'd1);
    chk($sformatf("v%0d busy_end", k), 32'(busy), 32'd0);
    chk($sformatf("v%0d sat", k), 32'(sat_flag), 32'(v.sat));
    chk($sformatf("v%0d nwr", k), 32'(wa_q.size()), 32'(v.nw));
    for (int i = 0; i < int'(v.nw); i++) begin
      if (i < wa_q.size()) begin
        chk($sformatf("v%0d addr%0d", k, i), 32'(wa_q[i]), 32'(v.wa[i]));
        chk($sformatf("v%0d data%0d", k, i), 32'(wd_q[i]), 32'(v.wd[i]));
      end
    end
  endtask

  initial begin
    vecs[0] = '0;
    vecs[0].cols = 8'd4; vecs[0].rows = 8'd2; vecs[0].base = 12'h010;
    vecs[0].n = 4'd8;
    for (int i = 0; i < 8; i++) vecs[0].samp[i] = 20'(i + 1);
    vecs[0].nw = 3'd4;
    vecs[0].wa[0] = 12'h010; vecs[0].wd[0] = 24'h030201;
    vecs[0].wa[1] = 12'h011; vecs[0].wd[1] = 24'h000004;
    vecs[0].wa[2] = 12'h012; vecs[0].wd[2] = 24'h070605;
    vecs[0].wa[3] = 12'h013; vecs[0].wd[3] = 24'h000008;
    vecs[0].sat = 1'b0;

    vecs[1] = '0;
    vecs[1].cols = 8'd3; vecs[1].rows = 8'd1; vecs[1].base = 12'h020;
    vecs[1].n = 4'd3;
    vecs[1].samp[0] = 20'(200);
    vecs[1].samp[1] = 20'(-300);
    vecs[1].samp[2] = 20'(5);
    vecs[1].nw = 3'd1;
    vecs[1].wa[0] = 12'h020;
`ifdef RESULT_WRITER_RELU_EN
    vecs[1].wd[0] = 24'h05007F;
`else
    vecs[1].wd[0] = 24'h05807F;
`endif
    vecs[1].sat = 1'b1;

    vecs[2] = '0;
    vecs[2].cols = 8'd5; vecs[2].rows = 8'd1; vecs[2].base = 12'hFFF;
    vecs[2].n = 4'd5;
    vecs[2].samp[0] = 20'(127);
    vecs[2].samp[1] = 20'(-128);
    vecs[2].samp[2] = 20'(128);
    vecs[2].samp[3] = 20'(-129);
    vecs[2].samp[4] = 20'(-1);
    vecs[2].nw = 3'd2;
    vecs[2].wa[0] = 12'hFFF;
    vecs[2].wa[1] = 12'h000;
`ifdef RESULT_WRITER_RELU_EN
    vecs[2].wd[0] = 24'h7F007F;
    vecs[2].wd[1] = 24'h000000;
`else
    vecs[2].wd[0] = 24'h7F807F;
    vecs[2].wd[1] = 24'h00FF80;
`endif
    vecs[2].sat = 1'b1;

    vecs[3] = '0;
    vecs[3].cols = 8'd1; vecs[3].rows = 8'd3; vecs[3].base = 12'h100;
    vecs[3].n = 4'd3; vecs[3].gap = 1'b1;
    vecs[3].samp[0] = 20'(10);
    vecs[3].samp[1] = 20'(20);
    vecs[3].samp[2] = 20'(30);
    vecs[3].nw = 3'd3;
    vecs[3].wa[0] = 12'h100; vecs[3].wd[0] = 24'h00000A;
    vecs[3].wa[1] = 12'h101; vecs[3].wd[1] = 24'h000014;
    vecs[3].wa[2] = 12'h102; vecs[3].wd[2] = 24'h00001E;
    vecs[3].sat = 1'b0;

    vecs[4] = '0;
    vecs[4].cols = 8'd6; vecs[4].rows = 8'd1; vecs[4].base = 12'h040;
    vecs[4].n = 4'd6;
    for (int i = 0; i < 6; i++) vecs[4].samp[i] = 20'(i + 1);
    vecs[4].nw = 3'd2;
    vecs[4].wa[0] = 12'h040; vecs[4].wd[0] = 24'h030201;
    vecs[4].wa[1] = 12'h041; vecs[4].wd[1] = 24'h060504;
    vecs[4].sat = 1'b0;

    reset_n      = 1'b0;
    start        = 1'b0;
    base_addr    = '0;
    out_cols     = '0;
    out_rows     = '0;
    result_data  = '0;
    result_valid = 1'b0;
    tick();
    tick();
    chk("rst wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst addr", 32'(mem_addr), 32'd0);
    chk("rst data", 32'(mem_wr_data), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst sat", 32'(sat_flag), 32'd0);
    chk("rst unexp", 32'(unexp_valid), 32'd0);
    reset_n = 1'b1;
    tick();

    for (int k = 0; k < 4; k++) run_vec(k, vecs[k]);

    clr_mon();
    out_cols  = 8'd4;
    out_rows  = 8'd0;
    base_addr = 12'h200;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    chk("empty done", 32'(done), 32'd1);
    chk("empty busy", 32'(busy), 32'd0);
    tick();
    chk("empty done_drop", 32'(done), 32'd0);
    tick();
    chk("empty nwr", 32'(wa_q.size()), 32'd0);
    chk("empty done_cnt", 32'(done_cnt), 32'd1);

    clr_mon();
    result_valid = 1'b1;
    result_data  = 20'(9);
    tick();
    tick();
    result_valid = 1'b0;
    tick();
    chk("idle unexp", 32'(unexp_valid), 32'd1);
    chk("idle nwr", 32'(wa_q.size()), 32'd0);
    out_rows = 8'd0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    chk("restart unexp", 32'(unexp_valid), 32'd0);
    tick();

    clr_mon();
    out_cols  = 8'd6;
    out_rows  = 8'd1;
    base_addr = 12'h040;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    for (int i = 0; i < 2; i++) begin
      result_valid = 1'b1;
      result_data  = 20'(300);
      tick();
    end
    result_valid = 1'b0;
    reset_n      = 1'b0;
    #2;
    chk("abort wr_en", 32'(mem_wr_en), 32'd0);
    chk("abort addr", 32'(mem_addr), 32'd0);
    chk("abort data", 32'(mem_wr_data), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort sat", 32'(sat_flag), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("abort nwr", 32'(wa_q.size()), 32'd0);
    run_vec(4, vecs[4]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
